// File: rtl/pulse_param_deframer_if.sv
// pulse_param_deframer_if: byte stream from the UART receiver into the parameter deframer
//   rx_data   8  received byte
//   rx_valid  1  one-cycle qualifier for rx_data
//   master drives the stream (UART receiver), slave consumes it (deframer)
interface pulse_param_deframer_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    modport master (output rx_data, rx_valid);
    modport slave  (input  rx_data, rx_valid);
endinterface

// File: rtl/pulse_param_deframer.sv
// pulse_param_deframer: parses checksummed parameter frames from the UART and drives the sequencer parameter bus
//   clk       in   system clock
//   reset     in   synchronous, active-high
//   rx        in   byte stream (slave modport: rx_data, rx_valid)
//   pu..bl    out  parallel parameter bus, changes only on an accepted frame
//   load      out  load strobe, high STROBE_CYCLES cycles starting one cycle after the bus updates
//   frame_ok  out  one-cycle pulse per accepted frame
//   frame_err out  one-cycle pulse per bad-checksum or timed-out frame
//   busy      out  high whenever the parser is not idle
module pulse_param_deframer #(
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
    parameter int          PAYLOAD_LEN    = 23,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd120000,
    parameter int          STROBE_CYCLES  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    pulse_param_deframer_if.slave  rx,
    output logic                   pu,
    output logic [7:0]             per,
    output logic [15:0]            p1wid,
    output logic [15:0]            del,
    output logic [15:0]            p2wid,
    output logic [31:0]            nut_w,
    output logic [31:0]            nut_d,
    output logic                   nut,
    output logic [7:0]             cp,
    output logic [7:0]             p_bl,
    output logic [15:0]            p_bl_off,
    output logic                   bl,
    output logic                   load,
    output logic                   frame_ok,
    output logic                   frame_err,
    output logic                   busy
);
    typedef struct packed {
        logic        pu;
        logic [7:0]  per;
        logic [15:0] p1wid;
        logic [15:0] del;
        logic [15:0] p2wid;
        logic [31:0] nut_w;
        logic [31:0] nut_d;
        logic        nut;
        logic [7:0]  cp;
        logic [7:0]  p_bl;
        logic [15:0] p_bl_off;
        logic        bl;
    } params_t;
    localparam params_t DEFAULTS = '{pu: 1'b1, per: 8'd1, p1wid: 16'd30, del: 16'd200, p2wid: 16'd30,
                                     nut_w: 32'd50, nut_d: 32'd300, nut: 1'b1, cp: 8'd3, p_bl: 8'd50,
                                     p_bl_off: 16'd100, bl: 1'b1};
    localparam logic [4:0] LAST = 5'(PAYLOAD_LEN - 1);
    localparam logic [3:0] SC   = 4'(STROBE_CYCLES);
    typedef enum logic [2:0] {IDLE, PAYLOAD, CHECK_WAIT, COMMIT, STROBE} state_t;
    state_t      state;
    params_t     sh, cur;
    logic [4:0]  idx;
    logic [7:0]  sum;
    logic [23:0] gap;
    logic [3:0]  cnt;
    wire  [7:0]  d = rx.rx_data;
    // Payload bytes are scattered straight into the shadow fields (big-endian);
    // the field map covers bytes 0..21, byte 22 is a reserved byte that only
    // contributes to the checksum.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            sum       <= '0;
            gap       <= '0;
            cnt       <= '0;
            load      <= 1'b0;
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            cur       <= DEFAULTS;
        end else begin
            frame_ok  <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: if (rx.rx_valid && d == SYNC_BYTE) begin
                    state <= PAYLOAD;
                    idx   <= '0;
                    sum   <= '0;
                    gap   <= '0;
                end
                PAYLOAD, CHECK_WAIT: if (rx.rx_valid) begin
                    gap <= '0;
                    sum <= sum + d;
                    if (state == CHECK_WAIT) begin
                        state     <= (sum + d == 8'h00) ? COMMIT : IDLE;
                        frame_err <= (sum + d != 8'h00);
                    end else begin
                        idx <= idx + 5'd1;
                        if (idx == LAST) state <= CHECK_WAIT;
                        case (idx)
                            5'd0:  sh.pu              <= d[0];
                            5'd1:  sh.per             <= d;
                            5'd2:  sh.p1wid[15:8]     <= d;
                            5'd3:  sh.p1wid[7:0]      <= d;
                            5'd4:  sh.del[15:8]       <= d;
                            5'd5:  sh.del[7:0]        <= d;
                            5'd6:  sh.p2wid[15:8]     <= d;
                            5'd7:  sh.p2wid[7:0]      <= d;
                            5'd8:  sh.nut_w[31:24]    <= d;
                            5'd9:  sh.nut_w[23:16]    <= d;
                            5'd10: sh.nut_w[15:8]     <= d;
                            5'd11: sh.nut_w[7:0]      <= d;
                            5'd12: sh.nut_d[31:24]    <= d;
                            5'd13: sh.nut_d[23:16]    <= d;
                            5'd14: sh.nut_d[15:8]     <= d;
                            5'd15: sh.nut_d[7:0]      <= d;
                            5'd16: sh.nut             <= d[0];
                            5'd17: sh.cp              <= d;
                            5'd18: sh.p_bl            <= d;
                            5'd19: sh.p_bl_off[15:8]  <= d;
                            5'd20: sh.p_bl_off[7:0]   <= d;
                            5'd21: sh.bl              <= d[0];
                            default: ;
                        endcase
                    end
                end else if (gap == TIMEOUT_CYCLES - 24'd1) begin
                    frame_err <= 1'b1;
                    state     <= IDLE;
                end else begin
                    gap <= gap + 24'd1;
                end
                COMMIT: begin
                    cur      <= sh;
                    frame_ok <= 1'b1;
                    cnt      <= '0;
                    state    <= STROBE;
                end
                // The bus settled one cycle ago; bytes arriving here are dropped.
                STROBE: begin
                    load  <= (cnt != SC);
                    cnt   <= (cnt != SC) ? cnt + 4'd1 : cnt;
                    state <= (cnt != SC) ? STROBE : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
    assign busy     = (state != IDLE);
    assign pu       = cur.pu;
    assign per      = cur.per;
    assign p1wid    = cur.p1wid;
    assign del      = cur.del;
    assign p2wid    = cur.p2wid;
    assign nut_w    = cur.nut_w;
    assign nut_d    = cur.nut_d;
    assign nut      = cur.nut;
    assign cp       = cur.cp;
    assign p_bl     = cur.p_bl;
    assign p_bl_off = cur.p_bl_off;
    assign bl       = cur.bl;
endmodule

// File: tb/tb_pulse_param_deframer.sv
// tb_pulse_param_deframer: directed frames against hand-computed parameter values and strobe timing
module tb_pulse_param_deframer;
    localparam logic [23:0] TO = 24'd300;
    logic clk = 1'b0;
    logic reset = 1'b1;
    pulse_param_deframer_if rx();
    logic pu, nut, bl, load, frame_ok, frame_err, busy;
    logic [7:0] per, cp, p_bl;
    logic [15:0] p1wid, del, p2wid, p_bl_off;
    logic [31:0] nut_w, nut_d;
    logic [7:0] pl [23];
    int checks = 0, failures = 0;
    int ok_n = 0, err_n = 0, load_n = 0;
    int ok0, err0, load0, first;

    pulse_param_deframer #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .rx(rx),
        .pu(pu), .per(per), .p1wid(p1wid), .del(del), .p2wid(p2wid),
        .nut_w(nut_w), .nut_d(nut_d), .nut(nut), .cp(cp), .p_bl(p_bl),
        .p_bl_off(p_bl_off), .bl(bl), .load(load), .frame_ok(frame_ok),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ok_n   += int'(frame_ok);
        err_n  += int'(frame_err);
        load_n += int'(load);
    end

    task check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task send_byte(input logic [7:0] b);
        rx.rx_data  = b;
        rx.rx_valid = 1'b1;
        @(negedge clk);
        rx.rx_valid = 1'b0;
    endtask

    task send_payload(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) send_byte(pl[i]);
    endtask

    task send_ck(input logic [7:0] adj);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 23; i++) s = s + pl[i];
        send_byte(8'h00 - s + adj);
    endtask

    task send_frame(input logic [7:0] adj);
        send_byte(8'hA5);
        send_payload(0, 22);
        send_ck(adj);
    endtask

    task do_reset;
        @(negedge clk);
        reset = 1'b1;
        rx.rx_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task set_defaults;
        pl = '{8'h01, 8'h01, 8'h00, 8'h1E, 8'h00, 8'hC8, 8'h00, 8'h1E,
               8'h00, 8'h00, 8'h00, 8'h32, 8'h00, 8'h00, 8'h01, 8'h2C,
               8'h01, 8'h03, 8'h32, 8'h00, 8'h64, 8'h01, 8'h00};
    endtask

    // per=5, p1wid=40, del=400, cp=1, everything else default
    task set_a;
        set_defaults();
        pl[1] = 8'h05;
        pl[3] = 8'h28;
        pl[4] = 8'h01;
        pl[5] = 8'h90;
        pl[17] = 8'h01;
    endtask

    task check_defaults(input string tag);
        check({tag, ".pu"}, pu, 1);
        check({tag, ".per"}, per, 1);
        check({tag, ".p1wid"}, p1wid, 30);
        check({tag, ".del"}, del, 200);
        check({tag, ".p2wid"}, p2wid, 30);
        check({tag, ".nut_w"}, nut_w, 50);
        check({tag, ".nut_d"}, nut_d, 300);
        check({tag, ".nut"}, nut, 1);
        check({tag, ".cp"}, cp, 3);
        check({tag, ".p_bl"}, p_bl, 50);
        check({tag, ".p_bl_off"}, p_bl_off, 100);
        check({tag, ".bl"}, bl, 1);
    endtask

    task snap;
        ok0 = ok_n;
        err0 = err_n;
        load0 = load_n;
    endtask

    initial begin
        rx.rx_data = 8'h00;
        rx.rx_valid = 1'b0;
        do_reset();
        @(negedge clk);
        check_defaults("rst");
        check("rst.load", load, 0);
        check("rst.busy", busy, 0);
        check("rst.ok", frame_ok, 0);
        check("rst.err", frame_err, 0);

        // good frame with cycle-exact strobe timing
        set_a();
        snap();
        send_byte(8'hA5);
        send_payload(0, 22);
        send_ck(8'h00);
        check("good.ok_T", frame_ok, 0);
        check("good.per_T", per, 1);
        @(negedge clk);
        check("good.ok_T1", frame_ok, 1);
        check("good.per_T1", per, 8'h05);
        check("good.load_T1", load, 0);
        @(negedge clk);
        check("good.load_T2", load, 1);
        check("good.ok_T2", frame_ok, 0);
        repeat (3) @(negedge clk);
        check("good.load_T5", load, 1);
        check("good.busy_T5", busy, 1);
        @(negedge clk);
        check("good.load_T6", load, 0);
        check("good.busy_T6", busy, 0);
        check("good.pu", pu, 1);
        check("good.p1wid", p1wid, 16'd40);
        check("good.del", del, 16'd400);
        check("good.p2wid", p2wid, 30);
        check("good.nut_w", nut_w, 50);
        check("good.nut_d", nut_d, 300);
        check("good.cp", cp, 1);
        check("good.p_bl_off", p_bl_off, 100);
        check("good.bl", bl, 1);
        check("good.ok_n", ok_n - ok0, 1);
        check("good.load_n", load_n - load0, 4);
        check("good.err_n", err_n - err0, 0);

        // checksum off by one
        do_reset();
        snap();
        send_frame(8'h01);
        repeat (10) @(negedge clk);
        check("badck.err_n", err_n - err0, 1);
        check("badck.ok_n", ok_n - ok0, 0);
        check("badck.load_n", load_n - load0, 0);
        check("badck.busy", busy, 0);
        check_defaults("badck");

        // inter-byte timeout after 10 payload bytes
        do_reset();
        snap();
        send_byte(8'hA5);
        send_payload(0, 9);
        first = 0;
        for (int i = 1; i <= int'(TO) + 5; i++) begin
            @(posedge clk);
            #1;
            if (frame_err && first == 0) first = i;
        end
        check("tmo.when", first, int'(TO));
        check("tmo.err_n", err_n - err0, 1);
        check("tmo.busy", busy, 0);
        check_defaults("tmo");
        @(negedge clk);
        send_frame(8'h00);
        repeat (10) @(negedge clk);
        check("tmo.next_ok", ok_n - ok0, 1);
        check("tmo.next_per", per, 8'h05);

        // garbage before a frame whose nut_w contains the sync value
        do_reset();
        set_defaults();
        pl[8] = 8'h12;
        pl[9] = 8'hA5;
        pl[10] = 8'h34;
        pl[11] = 8'h00;
        snap();
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        send_frame(8'h00);
        repeat (10) @(negedge clk);
        check("garb.err_n", err_n - err0, 0);
        check("garb.ok_n", ok_n - ok0, 1);
        check("garb.nut_w", nut_w, 32'h12A5_3400);
        check("garb.per", per, 1);

        // reset in the middle of a frame
        do_reset();
        set_a();
        snap();
        send_byte(8'hA5);
        send_payload(0, 11);
        do_reset();
        send_payload(12, 22);
        send_ck(8'h00);
        repeat (10) @(negedge clk);
        check("rstmid.ok_n", ok_n - ok0, 0);
        check("rstmid.load_n", load_n - load0, 0);
        check("rstmid.busy", busy, 0);
        check_defaults("rstmid");

        // second frame's sync lands in STROBE and is dropped
        do_reset();
        set_a();
        snap();
        send_frame(8'h00);
        repeat (2) @(negedge clk);
        check("b2b.busy_strobe", busy, 1);
        pl[1] = 8'h07;
        send_frame(8'h00);
        repeat (10) @(negedge clk);
        check("b2b.ok_n", ok_n - ok0, 1);
        check("b2b.load_n", load_n - load0, 4);
        check("b2b.per", per, 8'h05);
        check("b2b.busy", busy, 0);
        check("b2b.err_n", err_n - err0, 0);
        set_a();
        pl[17] = 8'h02;
        snap();
        send_frame(8'h00);
        repeat (10) @(negedge clk);
        check("third.ok_n", ok_n - ok0, 1);
        check("third.load_n", load_n - load0, 4);
        check("third.cp", cp, 2);
        check("third.per", per, 8'h05);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pulse_param_deframer.md
Name: pulse_param_deframer

Overview:
- Producer side of the pulse-sequencer parameter-load interface.
- Consumes bytes from the UART byte receiver, parses one fixed-length parameter frame and verifies its checksum.
- On a good frame, drives the full parallel parameter bus plus the load strobe that the pulse sequencer synchronises and samples.
- Bad or truncated frames never disturb the outputs.

Parameters:
- SYNC_BYTE, 8'hA5, frame start marker.
- PAYLOAD_LEN, 23, payload bytes between sync and checksum (fixed by field map below).
- TIMEOUT_CYCLES, 24'd120000, max clk cycles between consecutive bytes of one frame (10 ms at 12 MHz).
- STROBE_CYCLES, 4, cycles load is held high; must be ≥3 so the 2-flop synchroniser in the slower domain catches it.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle qualifier for rx_data.
- pu  out  1  pump (first pulse) enable.
- per  out  8  period, counter[23:16] units.
- p1wid  out  16  first pulse width, cycles.
- del  out  16  inter-pulse delay, cycles.
- p2wid  out  16  pi pulse width, cycles.
- nut_w  out  32  nutation pulse width.
- nut_d  out  32  nutation pulse delay from period end.
- nut  out  1  nutation enable.
- cp  out  8  mode: 0 CW, 1 Hahn, >1 CPMG count.
- p_bl  out  8  block lead time.
- p_bl_off  out  16  block-open window width.
- bl  out  1  blocking enable.
- load  out  1  parameter load strobe (drives sequencer rxd).
- frame_ok  out  1  one-cycle pulse per accepted frame.
- frame_err  out  1  one-cycle pulse per rejected/timed-out frame.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Frame: SYNC_BYTE, 23 payload bytes, 1 checksum byte. Multi-byte fields are big-endian.
- Payload field order: pu, per, p1wid[2], del[2], p2wid[2], nut_w[4], nut_d[4], nut, cp, p_bl, p_bl_off[2], bl.
- 1-bit fields take bit 0 of their byte; bits 7:1 are ignored.
- Checksum: 8-bit sum (mod 256) of all 23 payload bytes plus the checksum byte must equal 8'h00. The sync byte is excluded.
- States:
  - IDLE: rx_valid with rx_data==SYNC_BYTE → PAYLOAD, byte index=0, running sum=0, gap timer=0. Any other byte is discarded silently (no frame_err).
  - PAYLOAD: each rx_valid writes the byte into the shadow register at the current index, adds it to the sum and increments the index. After index 22 is stored → CHECK_WAIT. SYNC_BYTE inside the payload is ordinary data; there is no escaping.
  - CHECK_WAIT: next rx_valid adds to the sum. Sum==0 → COMMIT. Otherwise pulse frame_err → IDLE.
  - COMMIT: copy all shadow fields to the outputs in one cycle, pulse frame_ok → STROBE.
  - STROBE: load=1 for exactly STROBE_CYCLES cycles, then → IDLE. rx_valid bytes arriving in STROBE are dropped with no error.
- Gap timer: runs in PAYLOAD and CHECK_WAIT and clears on every rx_valid. Reaching TIMEOUT_CYCLES → pulse frame_err → IDLE; shadow contents are discarded.
- Latency: checksum byte at cycle T → outputs and frame_ok change at T+1 → load high at T+2 through T+1+STROBE_CYCLES.
- Outputs are stable for ≥1 cycle before load rises and never change while load=1.
- Reset (any state, including mid-frame or mid-STROBE): state=IDLE, load=0, frame_ok=0, frame_err=0, busy=0, counters cleared.
- Output reset values: pu=1, per=1, p1wid=30, del=200, p2wid=30, nut_w=50, nut_d=300, nut=1, cp=3, p_bl=50, p_bl_off=100, bl=1.
- Shadow registers are not reset-relevant: they are never visible on the outputs without a full good frame.
- No arithmetic on field values; widths pass through unchanged, with no range checks (cp=0 and per=0 are legal).

Test Plan:
- Good frame (per=8'h05, p1wid=16'd40, del=16'd400, cp=8'd1, others default, correct checksum) → frame_ok one cycle at T+1; outputs exactly equal the frame; load high 4 cycles from T+2.
- Same frame with the checksum byte incremented by 1 → frame_err one cycle; all outputs keep their reset values; load never asserts.
- Sync plus 10 payload bytes, then idle TIMEOUT_CYCLES+5 cycles → frame_err at gap==TIMEOUT_CYCLES; state IDLE; a following full good frame is then accepted.
- Garbage bytes 8'h00, 8'hFF, 8'h5A before a good frame whose nut_w payload contains 8'hA5 → no frame_err; frame accepted; nut_w carries the A5 byte intact.
- reset asserted after byte 12 of a frame, released, then remainder of the frame sent → no frame_ok, no load; outputs equal reset values.
- Two good frames back-to-back, second frame's sync arriving during STROBE → second frame's sync is dropped, so the second frame is not accepted; a third frame sent after busy falls is accepted with exactly 4-cycle load.
